// File: rtl/awgn_pkg.sv
// rtl/awgn_pkg.sv - shared sample/sigma types and fixed-point constants for the AWGN adder
package awgn_pkg;
   typedef logic signed [15:0] sample_t;
   typedef logic        [15:0] sigma_t;

   localparam int      SAMPLE_FRAC = 11;
   localparam int      SIGMA_FRAC  = 12;
   localparam sample_t SAMPLE_MAX  = 16'sh7FFF;
   localparam sample_t SAMPLE_MIN  = 16'sh8000;
endpackage

// File: rtl/awgn_sync_fifo.sv
// rtl/awgn_sync_fifo.sv - single-clock FIFO with occupancy count, full and empty
module awgn_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 16
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       push_i,
   input  logic [W-1:0]               push_data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               pop_data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;
   logic          wr_en;
   logic          rd_en;

   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign wr_en = push_i && (!full_o || pop_i);
   assign rd_en = pop_i && !empty_o;

   always_comb begin
      count_d = count_q;
      if (wr_en && !rd_en) begin
         count_d = count_q + (AW+1)'(1);
      end else if (rd_en && !wr_en) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/awgn_noise_adder.sv
// rtl/awgn_noise_adder.sv - buffers generator noise, scales it by sigma and adds it to the signal stream
module awgn_noise_adder
   import awgn_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CE_MARGIN  = 4,
   parameter int SAT_CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   output logic                 noise_ce,
   input  logic                 noise_valid,
   input  logic [15:0]          noise_data,
   input  logic [15:0]          sigma,
   input  logic                 sig_valid,
   output logic                 sig_ready,
   input  logic [15:0]          sig_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          out_data,
   output logic [SAT_CNT_W-1:0] sat_count,
   output logic                 noise_ovf
);
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int PROD_FRAC = SAMPLE_FRAC + SIGMA_FRAC;
   localparam int SHIFT     = PROD_FRAC - SAMPLE_FRAC;
   localparam logic signed [32:0] ROUND_BIAS = 33'(2 ** (SHIFT - 1));
   localparam logic signed [33:0] SUM_MAX    = 34'(SAMPLE_MAX);
   localparam logic signed [33:0] SUM_MIN    = 34'(SAMPLE_MIN);

   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic [15:0]        fifo_data;
   logic               adv;
   logic               accept;

   logic               noise_ce_q, noise_ce_d;
   logic               noise_ovf_q;
   logic               s1_valid_q;
   sample_t            s1_sig_q, s1_noise_q;
   logic               s2_valid_q;
   sample_t            s2_sig_q;
   logic signed [32:0] s2_prod_q, prod_d;
   logic               out_valid_q;
   sample_t            out_data_q, out_data_d;
   logic [SAT_CNT_W-1:0] sat_count_q, sat_count_d;

   logic signed [32:0] rounded;
   logic signed [33:0] sum;
   logic               clip;

   // Single stall enable: every stage moves together, so pairing stays 1:1.
   assign adv       = !out_valid_q || out_ready;
   assign sig_ready = adv && !fifo_empty;
   assign accept    = sig_valid && sig_ready;

   awgn_sync_fifo #(
      .DEPTH(FIFO_DEPTH),
      .W    (16)
   ) u_noise_fifo (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .push_i     (noise_valid),
      .push_data_i(noise_data),
      .pop_i      (accept),
      .pop_data_o (fifo_data),
      .count_o    (fifo_count),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   always_comb begin
      noise_ce_d  = (int'(fifo_count) + 1) <= (FIFO_DEPTH - CE_MARGIN);
      prod_d      = 33'(s1_noise_q) * $signed({17'b0, sigma});
      rounded     = (s2_prod_q + ROUND_BIAS) >>> SHIFT;
      sum         = 34'(s2_sig_q) + 34'(rounded);
      clip        = 1'b0;
      out_data_d  = sample_t'(sum[15:0]);
      if (sum > SUM_MAX) begin
         out_data_d = SAMPLE_MAX;
         clip       = 1'b1;
      end else if (sum < SUM_MIN) begin
         out_data_d = SAMPLE_MIN;
         clip       = 1'b1;
      end
      sat_count_d = sat_count_q;
      if (s2_valid_q && clip && (sat_count_q != '1)) begin
         sat_count_d = sat_count_q + SAT_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         noise_ce_q  <= 1'b0;
         noise_ovf_q <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_sig_q    <= '0;
         s1_noise_q  <= '0;
         s2_valid_q  <= 1'b0;
         s2_sig_q    <= '0;
         s2_prod_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_count_q <= '0;
      end else begin
         noise_ce_q  <= noise_ce_d;
         noise_ovf_q <= noise_ovf_q | (noise_valid && fifo_full && !accept);
         if (adv) begin
            s1_valid_q  <= accept;
            if (accept) begin
               s1_sig_q   <= sig_data;
               s1_noise_q <= fifo_data;
            end
            s2_valid_q  <= s1_valid_q;
            s2_sig_q    <= s1_sig_q;
            s2_prod_q   <= prod_d;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
               out_data_q <= out_data_d;
            end
            sat_count_q <= sat_count_d;
         end
      end
   end

   assign noise_ce  = noise_ce_q;
   assign noise_ovf = noise_ovf_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sat_count = sat_count_q;
endmodule

// File: tb/tb_awgn_noise_adder.sv
// tb/tb_awgn_noise_adder.sv - directed self-checking bench for awgn_noise_adder
module tb_awgn_noise_adder;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        noise_ce;
   logic        noise_valid = 1'b0;
   logic [15:0] noise_data = '0;
   logic [15:0] sigma = '0;
   logic        sig_valid = 1'b0;
   logic        sig_ready;
   logic [15:0] sig_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [15:0] sat_count;
   logic        noise_ovf;

   int checks = 0;
   int errors = 0;

   awgn_noise_adder #(.FIFO_DEPTH(8), .CE_MARGIN(4), .SAT_CNT_W(16)) dut (
      .clk(clk), .rstn(rstn), .noise_ce(noise_ce), .noise_valid(noise_valid),
      .noise_data(noise_data), .sigma(sigma), .sig_valid(sig_valid),
      .sig_ready(sig_ready), .sig_data(sig_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .sat_count(sat_count),
      .noise_ovf(noise_ovf)
   );

   always #5 clk = ~clk;

   // Pushes one noise sample, offers one signal sample, returns the result and accept-to-valid latency.
   task automatic run_one(input logic [15:0] s, input logic [15:0] n,
                          output logic [15:0] got, output int lat);
      bit acc = 0;
      got = 'x;
      lat = -1;
      @(negedge clk);
      noise_valid = 1'b1; noise_data = n; sig_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      noise_valid = 1'b0; sig_valid = 1'b1; sig_data = s;
      for (int k = 0; k < 8 && !acc; k++) begin
         #1;
         if (sig_ready) acc = 1;
         else @(negedge clk);
      end
      @(negedge clk);
      sig_valid = 1'b0;
      if (acc) begin
         for (int k = 1; k <= 8 && lat < 0; k++) begin
            #1;
            if (out_valid) begin
               lat = k;
               got = out_data;
            end else begin
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; sig_valid = 1'b1; noise_valid = 1'b1; noise_data = 16'h0123;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({noise_ce, sig_ready, out_valid, noise_ovf} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags got %b exp 0000", {noise_ce, sig_ready, out_valid, noise_ovf});
      end
      checks++;
      if ({out_data, sat_count} !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got %h exp 00000000", {out_data, sat_count});
      end
      @(negedge clk);
      sig_valid = 1'b0; noise_valid = 1'b0; rstn = 1'b1;
      #1;
      checks++;
      if (noise_ce !== 1'b0) begin
         errors++;
         $display("FAIL ce_first_cycle got %b exp 0", noise_ce);
      end
      @(negedge clk);
      #1;
      checks++;
      if (noise_ce !== 1'b1) begin
         errors++;
         $display("FAIL ce_second_cycle got %b exp 1", noise_ce);
      end
   endtask

   task automatic test_unit_gain();
      logic [15:0] got;
      int lat;
      sigma = 16'h1000;
      run_one(16'h0400, 16'h0800, got, lat);
      checks++;
      if (got !== 16'h0C00) begin
         errors++;
         $display("FAIL unit_gain_data got %h exp 0c00", got);
      end
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL unit_gain_latency got %0d exp 3", lat);
      end
      checks++;
      if (sat_count !== 16'd0) begin
         errors++;
         $display("FAIL unit_gain_sat got %0d exp 0", sat_count);
      end
   endtask

   task automatic test_saturation();
      logic [15:0] got;
      int lat;
      sigma = 16'h1000;
      run_one(16'h7F00, 16'h1000, got, lat);
      checks++;
      if (got !== 16'h7FFF) begin
         errors++;
         $display("FAIL sat_pos_data got %h exp 7fff", got);
      end
      checks++;
      if (sat_count !== 16'd1) begin
         errors++;
         $display("FAIL sat_pos_count got %0d exp 1", sat_count);
      end
      run_one(16'h8100, 16'hF000, got, lat);
      checks++;
      if (got !== 16'h8000) begin
         errors++;
         $display("FAIL sat_neg_data got %h exp 8000", got);
      end
      checks++;
      if (sat_count !== 16'd2) begin
         errors++;
         $display("FAIL sat_neg_count got %0d exp 2", sat_count);
      end
   endtask

   task automatic test_rounding();
      logic [15:0] got;
      logic [15:0] noise_v [3] = '{16'h0001, 16'hFFFF, 16'h0003};
      logic [15:0] exp_v   [3] = '{16'h0101, 16'h0100, 16'h0102};
      int lat;
      sigma = 16'h0800;
      for (int i = 0; i < 3; i++) begin
         run_one(16'h0100, noise_v[i], got, lat);
         checks++;
         if (got !== exp_v[i]) begin
            errors++;
            $display("FAIL rounding_%0d got %h exp %h", i, got, exp_v[i]);
         end
      end
   endtask

   task automatic test_starvation();
      int lat = -1;
      sigma = 16'h1000; out_ready = 1'b1;
      @(negedge clk);
      sig_valid = 1'b1; sig_data = 16'h0200; noise_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({sig_ready, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL starve_%0d got %b exp 00", i, {sig_ready, out_valid});
         end
         @(negedge clk);
      end
      noise_valid = 1'b1; noise_data = 16'h0100;
      #1;
      checks++;
      if (sig_ready !== 1'b0) begin
         errors++;
         $display("FAIL starve_push_cycle got %b exp 0", sig_ready);
      end
      @(negedge clk);
      noise_valid = 1'b0;
      #1;
      checks++;
      if (sig_ready !== 1'b1) begin
         errors++;
         $display("FAIL starve_next_cycle got %b exp 1", sig_ready);
      end
      @(negedge clk);
      sig_valid = 1'b0;
      for (int k = 0; k < 8 && lat < 0; k++) begin
         #1;
         if (out_valid) lat = k;
         else @(negedge clk);
      end
      checks++;
      if (lat < 0 || out_data !== 16'h0300) begin
         errors++;
         $display("FAIL starve_data got %h exp 0300", out_data);
      end
   endtask

   task automatic test_backpressure();
      logic [2:0]  gpipe = '0;
      logic [15:0] nq[$];
      logic [15:0] eq[$];
      logic [15:0] held = '0;
      logic [15:0] e;
      bit          held_v = 0;
      bit          ce_dropped = 0;
      int          gidx = 0, sidx = 0, outs = 0, accepts = 0;
      sigma = 16'h1000;
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk);
         out_ready   = (cyc >= 20);
         sig_valid   = (cyc < 50);
         sig_data    = 16'(sidx * 64 - 500);
         noise_valid = gpipe[2];
         noise_data  = 16'(gidx * 8 + 3);
         gpipe       = {gpipe[1:0], noise_ce};
         #1;
         if (!noise_ce) ce_dropped = 1;
         if (out_valid && !out_ready) begin
            checks++;
            if (sig_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_sig_ready cyc %0d got %b exp 0", cyc, sig_ready);
            end
            if (held_v) begin
               checks++;
               if (out_data !== held) begin
                  errors++;
                  $display("FAIL stall_out_data cyc %0d got %h exp %h", cyc, out_data, held);
               end
            end
            held = out_data;
            held_v = 1;
         end
         if (out_valid && out_ready) begin
            held_v = 0;
            outs++;
            checks++;
            if (eq.size() == 0) begin
               errors++;
               $display("FAIL bp_spurious cyc %0d got %h exp none", cyc, out_data);
            end else begin
               e = eq.pop_front();
               if (out_data !== e) begin
                  errors++;
                  $display("FAIL bp_order cyc %0d got %h exp %h", cyc, out_data, e);
               end
            end
         end
         if (sig_valid && sig_ready) begin
            if (nq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bp_pairing cyc %0d got accept exp no noise", cyc);
            end else begin
               eq.push_back(sig_data + nq.pop_front());
            end
            sidx++;
            accepts++;
         end
         if (noise_valid) begin
            nq.push_back(noise_data);
            gidx++;
         end
      end
      noise_valid = 1'b0;
      checks++;
      if (eq.size() != 0 || outs != accepts) begin
         errors++;
         $display("FAIL bp_drain got %0d outputs exp %0d", outs, accepts);
      end
      checks++;
      if (ce_dropped !== 1'b1) begin
         errors++;
         $display("FAIL bp_ce_drop got %b exp 1", ce_dropped);
      end
      checks++;
      if (noise_ovf !== 1'b0) begin
         errors++;
         $display("FAIL bp_ovf got %b exp 0", noise_ovf);
      end
   endtask

   task automatic test_reset_midstream();
      logic [15:0] got;
      int lat;
      sigma = 16'h1000; out_ready = 1'b0; sig_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         noise_valid = 1'b1; noise_data = 16'h0400;
      end
      @(negedge clk);
      noise_valid = 1'b0; sig_valid = 1'b1; sig_data = 16'h0100;
      #1;
      checks++;
      if (noise_ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set got %b exp 1", noise_ovf);
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if ({out_valid, sig_ready} !== 2'b10) begin
         errors++;
         $display("FAIL mid_prestate got %b exp 10", {out_valid, sig_ready});
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({noise_ce, sig_ready, out_valid, noise_ovf, out_data, sat_count} !== 36'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs got %h exp 0",
                  {noise_ce, sig_ready, out_valid, noise_ovf, out_data, sat_count});
      end
      @(negedge clk);
      rstn = 1'b1; sig_valid = 1'b0;
      #1;
      checks++;
      if ({noise_ce, noise_ovf} !== 2'b00) begin
         errors++;
         $display("FAIL mid_release got %b exp 00", {noise_ce, noise_ovf});
      end
      run_one(16'h0100, 16'h0010, got, lat);
      checks++;
      if (got !== 16'h0110) begin
         errors++;
         $display("FAIL mid_post_data got %h exp 0110", got);
      end
      checks++;
      if (sat_count !== 16'd0) begin
         errors++;
         $display("FAIL mid_post_sat got %0d exp 0", sat_count);
      end
   endtask

   initial begin
      test_reset();
      test_unit_gain();
      test_saturation();
      test_rounding();
      test_starvation();
      test_backpressure();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/awgn_noise_adder.md
Name: awgn_noise_adder

Overview:
Channel stage directly downstream of the boxmuller AWGN generator. It throttles the generator through its ce input and buffers its 16-bit noise samples in a small FIFO. Each noise sample is scaled by a programmable sigma and added to a valid/ready signal stream, with rounding and saturation. The output is the noisy channel sample stream, which feeds the demodulator and capture logic.

Parameters:
FIFO_DEPTH, 8, noise FIFO entries; power of 2, minimum 4.
CE_MARGIN, 4, free FIFO slots reserved for noise samples still in flight in the generator pipeline.
SAT_CNT_W, 16, width of the saturation event counter.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
noise_ce  out  1  clock enable to boxmuller ce
noise_valid  in  1  boxmuller valid_out
noise_data  in  16  boxmuller data_out; signed Q5.11
sigma  in  16  unsigned Q4.12 noise scale; quasi-static, change only while idle
sig_valid  in  1  input signal sample valid
sig_ready  out  1  input signal sample accepted when sig_valid && sig_ready
sig_data  in  16  signed Q5.11 signal sample
out_valid  out  1  output sample valid
out_ready  in  1  downstream ready
out_data  out  16  signed Q5.11 noisy sample
sat_count  out  SAT_CNT_W  saturating count of clipped outputs
noise_ovf  out  1  sticky flag: noise sample arrived while FIFO full

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn. While reset is asserted:
  - noise_ce=0, sig_ready=0, out_valid=0, out_data=0, sat_count=0, noise_ovf=0.
  - FIFO pointers and count cleared; all pipeline valids cleared.
- Reset mid-operation discards in-flight samples and FIFO contents. noise_ce stays 0 for the first cycle after release.
- noise_ce: registered; next value = (fifo_count + 1 <= FIFO_DEPTH - CE_MARGIN).
- FIFO push: on noise_valid=1.
  - If the FIFO is full, the sample is dropped and noise_ovf is set; noise_ovf clears only on reset.
  - Push and pop in the same cycle are legal; count is unchanged, including at full and at empty+push. A push to an empty FIFO is not poppable until the next cycle.
- Pipeline advance: adv = !out_valid || out_ready (global stall enable).
- Accept: sig_ready = adv && fifo_not_empty (combinational).
  - On accept, one noise sample is popped and paired with sig_data.
  - Pairing is strictly 1:1 and in order.
- S1 (accept cycle): register the signal sample and the popped noise sample.
- S2: product = signed(noise) * signed({1'b0,sigma}); 33-bit signed, 23 fractional bits.
- S3:
  - scaled = (product + 2^11) >>> 12, arithmetic shift, i.e. round half up.
  - sum = sig + scaled, computed at full width.
  - Saturate to [-32768, 32767].
  - Register out_data and set out_valid.
  - If clipped, sat_count increments, holding at all-ones.
- Latency: accept to out_valid is 3 cycles with no stall. Throughput is 1 sample/cycle when noise is available.
- Stall: with out_valid && !out_ready, all stages hold, out_data is stable, and sig_ready=0.
- sigma=0 gives pass-through: out = sig.

Decomposition:
- Package awgn_pkg holds:
  - typedefs sample_t (logic signed [15:0]) and sigma_t (logic [15:0]);
  - constants SAMPLE_FRAC=11, SIGMA_FRAC=12, SAMPLE_MAX=16'sh7FFF, SAMPLE_MIN=16'sh8000.
- One sub-module, awgn_sync_fifo: parameterised sync FIFO exposing count, full and empty; instantiated for the noise buffer.

Test Plan:
- Unit gain: sigma=0x1000, noise=0x0800, sig=0x0400, out_ready=1 -> out_data=0x0C00 exactly 3 cycles after accept; sat_count=0.
- Saturation:
  - sig=0x7F00, noise=0x1000, sigma=0x1000 -> out_data=0x7FFF, sat_count=1.
  - sig=0x8100, noise=0xF000 -> out_data=0x8000, sat_count=2.
- Rounding: sigma=0x0800.
  - noise=0x0001 -> scaled=+1, out=sig+1.
  - noise=0xFFFF -> scaled=0, out=sig.
  - noise=0x0003 -> out=sig+2.
- Backpressure:
  - Hold out_ready=0 for 20 cycles with sig_valid=1 and a generator model of latency CE_MARGIN-1 -> out_data stable and sig_ready=0.
  - noise_ce drops once fifo_count > FIFO_DEPTH-CE_MARGIN-1; noise_ovf stays 0; no sample is lost or reordered after release.
- Noise starvation: noise_valid=0 with sig_valid=1 -> sig_ready=0 and out_valid=0; the first noise sample enables the accept one cycle after its push.
- Reset mid-stream: assert rstn=0 with 3 samples in flight and 5 in the FIFO -> all outputs 0 immediately. After release, the first output uses only post-reset noise; sat_count=0.
